// File: rtl/level_cost_accum.sv
// rtl/level_cost_accum.sv - saturating cost accumulator over 4x4 blocks of quantised levels
module level_cost_accum #(
    parameter int BIT_WIDTH  = 16,
    parameter int MAX_BLOCKS = 16,
    parameter int NB_W       = $clog2(MAX_BLOCKS + 1)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic                              clear,
    input  logic [1:0]                        mode,
    input  logic [NB_W-1:0]                   num_blocks,
    input  logic [BIT_WIDTH*16*MAX_BLOCKS-1:0] levels,
    output logic [31:0]                       sum,
    output logic                              done,
    output logic                              busy,
    output logic                              sat
);
    // Wide enough for the worst-case sum of squares over a full run, never below 40 bits.
    localparam int SUM_W = 2 * BIT_WIDTH - 1 + $clog2(16 * MAX_BLOCKS);
    localparam int ACC_W = (SUM_W > 40) ? SUM_W : 40;
    localparam int BLK_W = 16 * BIT_WIDTH;

    typedef enum logic [1:0] {IDLE, ACCUM, FINISH} state_t;

    state_t            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [NB_W-1:0]   n_q, n_d;
    logic [NB_W-1:0]   idx_q, idx_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [31:0]       sum_q, sum_d;
    logic              sat_q, sat_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    logic [BLK_W-1:0]       blk;
    logic [ACC_W-1:0]       blk_sum;
    logic [ACC_W-1:0]       term;
    logic [BIT_WIDTH:0]     x_ext;
    logic [BIT_WIDTH:0]     x_abs;
    logic [2*BIT_WIDTH-1:0] x_wide;
    logic [2*BIT_WIDTH-1:0] x_sq;
    logic [NB_W-1:0]        n_req;
    logic                   ovf;

    always_comb begin
        blk = '0;
        for (int b = 0; b < MAX_BLOCKS; b++) begin
            if (idx_q == NB_W'(b)) begin
                blk = levels[b*BLK_W +: BLK_W];
            end
        end
        blk_sum = '0;
        term    = '0;
        x_ext   = '0;
        x_abs   = '0;
        x_wide  = '0;
        x_sq    = '0;
        for (int c = 0; c < 16; c++) begin
            // One extra bit lets the most negative level negate to +2^(BIT_WIDTH-1).
            x_ext  = {blk[c*BIT_WIDTH+BIT_WIDTH-1], blk[c*BIT_WIDTH +: BIT_WIDTH]};
            x_abs  = x_ext[BIT_WIDTH] ? (~x_ext + 1'b1) : x_ext;
            x_wide = {{BIT_WIDTH{x_ext[BIT_WIDTH]}}, x_ext[BIT_WIDTH-1:0]};
            x_sq   = x_wide * x_wide;
            case (mode_q)
                2'd1:    term = ACC_W'(x_abs);
                2'd2:    term = ACC_W'(|x_ext);
                default: term = ACC_W'(x_sq);
            endcase
            blk_sum = blk_sum + term;
        end
    end

    assign n_req = ((num_blocks == '0) || (num_blocks > NB_W'(MAX_BLOCKS)))
                   ? NB_W'(MAX_BLOCKS) : num_blocks;
    assign ovf   = |acc_q[ACC_W-1:32];

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        n_d     = n_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        sat_d   = sat_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    n_d     = n_req;
                    idx_d   = '0;
                    acc_d   = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                acc_d = acc_q + blk_sum;
                idx_d = idx_q + NB_W'(1);
                if (idx_q == n_q - NB_W'(1)) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                sum_d   = ovf ? 32'hFFFF_FFFF : acc_q[31:0];
                sat_d   = ovf;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Abort wins over everything, including a start in the same cycle.
        if (clear) begin
            state_d = IDLE;
            done_d  = 1'b0;
            sum_d   = sum_q;
            sat_d   = sat_q;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mode_q  <= '0;
            n_q     <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            sat_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            sat_q   <= sat_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign sum  = sum_q;
    assign sat  = sat_q;
    assign done = done_q;
    assign busy = busy_q;
endmodule

// File: tb/tb_level_cost_accum.sv
// tb/tb_level_cost_accum.sv - directed scoreboard bench for level_cost_accum
module tb_level_cost_accum;
    logic                  clk = 1'b0;
    logic                  rst_n = 1'b1;
    logic                  start = 1'b0;
    logic                  clear = 1'b0;
    logic [1:0]            mode = 2'd0;
    logic [4:0]            num_blocks = 5'd0;
    logic [255:0][15:0]    lv = '0;
    logic [31:0]           sum;
    logic                  done;
    logic                  busy;
    logic                  sat;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] sum;
        logic        sat;
    } exp_t;
    exp_t sb[$];

    level_cost_accum dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .clear      (clear),
        .mode       (mode),
        .num_blocks (num_blocks),
        .levels     (lv),
        .sum        (sum),
        .done       (done),
        .busy       (busy),
        .sat        (sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input int n, input logic [1:0] md);
        longint acc = 0;
        logic signed [15:0] x;
        exp_t e;
        for (int b = 0; b < n; b++) begin
            for (int c = 0; c < 16; c++) begin
                x = signed'(lv[8'(16*b+c)]);
                case (md)
                    2'd1:    acc += (x < 0) ? -longint'(x) : longint'(x);
                    2'd2:    acc += (x != 0) ? 1 : 0;
                    default: acc += longint'(x) * longint'(x);
                endcase
            end
        end
        e.sat = (acc > 64'hFFFF_FFFF);
        e.sum = e.sat ? 32'hFFFF_FFFF : acc[31:0];
        return e;
    endfunction

    task automatic set_all(input logic [15:0] v);
        for (int i = 0; i < 256; i++) lv[8'(i)] = v;
    endtask

    task automatic run(input int nb, input logic [1:0] md, input int n_eff, input string tag);
        exp_t e;
        bit   got = 1'b0;
        sb.push_back(model(n_eff, md));
        num_blocks = 5'(nb);
        mode       = md;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= n_eff + 4 && !got; k++) begin
            @(posedge clk); #1;
            if (done) begin
                got = 1'b1;
                chk({tag, "_latency"}, 64'(k), 64'(n_eff + 1));
                chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
                e = sb.pop_front();
                chk({tag, "_sum"}, 64'(sum), 64'(e.sum));
                chk({tag, "_sat"}, 64'(sat), 64'(e.sat));
            end else if (k <= n_eff) begin
                chk({tag, "_busy"}, 64'(busy), 64'd1);
            end
        end
        if (!got) chk({tag, "_done_timeout"}, 64'(done), 64'd1);
        @(posedge clk); #1;
        chk({tag, "_done_single"}, 64'(done), 64'd0);
    endtask

    initial begin
        exp_t e;
        int   ndone;
        int   first;
        logic prev;
        logic [31:0] held_sum;

        #2 rst_n = 1'b0;
        #10;
        chk("reset_sum", 64'(sum), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_sat", 64'(sat), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        set_all(16'd1);
        run(8, 2'd0, 8, "sq_n8_ones");

        set_all(16'h8000);
        run(16, 2'd0, 16, "sq_n16_min");
        run(16, 2'd1, 16, "abs_n16_min");
        run(16, 2'd3, 16, "rsv_n16_min");

        for (int i = 0; i < 256; i++) lv[8'(i)] = (i % 2 == 0) ? 16'hFFFD : 16'h0000;
        run(16, 2'd2, 16, "nz_n16_even");
        run(0, 2'd2, 16, "nz_n0");
        run(20, 2'd2, 16, "nz_n20");

        // start held high across two runs
        set_all(16'd2);
        sb.push_back(model(8, 2'd0));
        sb.push_back(model(8, 2'd0));
        held_sum   = 32'd0;
        num_blocks = 5'd8;
        mode       = 2'd0;
        start      = 1'b1;
        ndone      = 0;
        first      = 0;
        prev       = 1'b0;
        @(posedge clk); #1;
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk); #1;
            if (k == 19) start = 1'b0;
            if (done) begin
                ndone++;
                chk("held_no_double", 64'(prev), 64'd0);
                if (ndone == 1) begin
                    first = k;
                    chk("held_first_latency", 64'(k), 64'd9);
                end else begin
                    chk("held_gap", 64'(k - first), 64'd10);
                end
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    held_sum = e.sum;
                    chk("held_sum", 64'(sum), 64'(e.sum));
                    chk("held_sat", 64'(sat), 64'(e.sat));
                end
            end
            prev = done;
        end
        chk("held_runs", 64'(ndone), 64'd2);

        // clear sampled at E3 of an n=8 run
        num_blocks = 5'd8;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        chk("clear_busy", 64'(busy), 64'd0);
        ndone = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("clear_no_done", 64'(ndone), 64'd0);
        chk("clear_sum_kept", 64'(sum), 64'(held_sum));
        run(8, 2'd0, 8, "after_clear");

        // asynchronous reset between edges mid-run
        set_all(16'd7);
        num_blocks = 5'd8;
        mode  = 2'd1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_sum", 64'(sum), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_sat", 64'(sat), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run(8, 2'd1, 8, "after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
